// File: rtl/sme_arb.sv
// sme_arb: two-requester round-robin front end for a string matching engine.
//
// A granted requester streams characters (with isstring/ispattern qualifiers)
// to the matcher. When that requester drops req, the block waits for the matcher
// result and reports it for one cycle, tagged with the id of the served requester.
//
// Ports:
//   clk, reset                 single clock; asynchronous active-high reset
//   req0/req1                  job requests, held high for a whole job
//   gnt0/gnt1                  registered one-hot grants
//   d0/d1, s0/s1, p0/p1        per-requester char data and qualifiers
//   sme_chardata/isstring/ispattern  muxed stream (0 outside STREAM)
//   sme_valid/match/match_index      matcher result, used only in WAIT
//   res_valid/id/match/index/timeout tagged result; res_valid pulses in REPORT
//   busy                       high whenever the block is not IDLE
//
// Build option: define SME_ARB_TIMEOUT_EN to bound WAIT to TIMEOUT_CYC cycles.
// Without it the counter is absent and res_timeout is tied low.
module sme_arb #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic       s0,
  input  logic       s1,
  input  logic       p0,
  input  logic       p1,
  output logic [7:0] sme_chardata,
  output logic       sme_isstring,
  output logic       sme_ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  output logic       res_id,
  output logic       res_match,
  output logic       res_timeout,
  output logic [4:0] res_index,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, REPORT} state_t;

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       sel_q, sel_d;        // requester owning the current job
  logic       last_q, last_d;      // requester served last (1 = req1)
  logic       sent_q, sent_d;
  logic       res_id_q, res_id_d;
  logic       res_match_q, res_match_d;
  logic [4:0] res_index_q, res_index_d;
`ifdef SME_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);
  logic [7:0] cnt_q, cnt_d;
  logic       res_timeout_q, res_timeout_d;
`endif

  logic cur_req;
  logic cur_sp;

  always_comb begin
    cur_req = sel_q ? req1 : req0;
    cur_sp  = sel_q ? (s1 | p1) : (s0 | p0);
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    last_d      = last_q;
    sent_d      = sent_q;
    res_id_d    = res_id_q;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
`ifdef SME_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    res_timeout_d = res_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins.
          sel_d   = (req0 && req1) ? ~last_q : req1;
          gnt_d   = sel_d ? 2'b10 : 2'b01;
          sent_d  = 1'b0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (cur_req) begin
          if (cur_sp) sent_d = 1'b1;
        end else begin
          gnt_d = '0;
          if (sent_q) begin
            state_d = WAIT;
            last_d  = sel_q;
`ifdef SME_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT: begin
        if (sme_valid) begin
          res_id_d    = sel_q;
          res_match_d = sme_match;
          res_index_d = sme_match_index;
`ifdef SME_ARB_TIMEOUT_EN
          res_timeout_d = 1'b0;
`endif
          state_d     = REPORT;
        end
`ifdef SME_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO_LIMIT) begin
            res_id_d      = sel_q;
            res_match_d   = 1'b0;
            res_index_d   = '0;
            res_timeout_d = 1'b1;
            state_d       = REPORT;
          end
        end
`endif
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      sent_q      <= 1'b0;
      res_id_q    <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
`ifdef SME_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      res_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      sent_q      <= sent_d;
      res_id_q    <= res_id_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
`ifdef SME_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

  always_comb begin
    sme_chardata  = '0;
    sme_isstring  = 1'b0;
    sme_ispattern = 1'b0;
    if (state_q == STREAM) begin
      sme_chardata  = sel_q ? d1 : d0;
      sme_isstring  = sel_q ? s1 : s0;
      sme_ispattern = sel_q ? p1 : p0;
    end
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign res_valid = (state_q == REPORT);
  assign res_id    = res_id_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
  assign busy      = (state_q != IDLE);
`ifdef SME_ARB_TIMEOUT_EN
  assign res_timeout = res_timeout_q;
`else
  assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sme_arb.sv
module tb_sme_arb;
  localparam int unsigned TO = 4;
`ifdef SME_ARB_TIMEOUT_EN
  localparam int KMAX = TO;
`else
  localparam int KMAX = 6;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, gnt0, gnt1;
  logic [7:0] d0, d1, sme_chardata;
  logic       s0, s1, p0, p1, sme_isstring, sme_ispattern;
  logic       sme_valid, sme_match;
  logic [4:0] sme_match_index, res_index;
  logic       res_valid, res_id, res_match, res_timeout, busy;

  sme_arb #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .d0(d0), .d1(d1), .s0(s0), .s1(s1), .p0(p0), .p1(p1),
    .sme_chardata(sme_chardata), .sme_isstring(sme_isstring), .sme_ispattern(sme_ispattern),
    .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index),
    .res_valid(res_valid), .res_id(res_id), .res_match(res_match),
    .res_timeout(res_timeout), .res_index(res_index), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic       match;
    logic [4:0] idx;
    logic       tmo;
  } res_t;
  typedef logic [9:0] job_t[$];   // {s, p, d}

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  bit   model_last = 1'b1;         // requester served last; 1 after reset

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input bit r, input logic v);
    if (r) req1 = v; else req0 = v;
  endtask

  task automatic set_data(input bit r, input logic [7:0] d, input logic s, input logic p);
    if (r) begin d1 = d; s1 = s; p1 = p; end
    else   begin d0 = d; s0 = s; p0 = p; end
  endtask

  task automatic junk(input bit r);
    logic [7:0] d;
    d = ($urandom_range(0, 1) == 1) ? 8'h41 : 8'($urandom);
    set_data(r, d, 1'($urandom), 1'($urandom));
  endtask

  function automatic job_t mk_job(input bit do_sp);
    job_t j;
    int   n;
    logic s, p;
    n = $urandom_range(1, 5);
    for (int i = 0; i < n; i++) begin
      s = 1'b0;
      p = 1'b0;
      if (do_sp) begin
        s = 1'($urandom);
        p = 1'($urandom);
      end
      j.push_back({s, p, 8'($urandom)});
    end
    if (do_sp) j[0][9] = 1'b1;
    return j;
  endfunction

  task automatic expect_grant(input bit r);
    step();
    chk("gnt_after_req", {30'b0, gnt1, gnt0}, r ? 32'd2 : 32'd1);
    chk("busy_in_stream", 32'(busy), 32'd1);
  endtask

  // Entered at the negedge where the grant is visible; returns at an IDLE negedge.
  task automatic serve(input bit r, input bit tmo, input job_t job,
                       input int k_in, input bit m_in, input logic [4:0] i_in);
    bit         sent = 1'b0;
    int         k, cycles;
    bit         m;
    logic [4:0] ix;
    foreach (job[i]) begin
      set_data(r, job[i][7:0], job[i][9], job[i][8]);
      junk(!r);
      sme_valid       = 1'($urandom);
      sme_match       = 1'($urandom);
      sme_match_index = 5'($urandom);
      #1;
      chk("stream_chardata", 32'(sme_chardata), 32'(job[i][7:0]));
      chk("stream_isstring", 32'(sme_isstring), 32'(job[i][9]));
      chk("stream_ispattern", 32'(sme_ispattern), 32'(job[i][8]));
      chk("stream_gnt", {30'b0, gnt1, gnt0}, r ? 32'd2 : 32'd1);
      sent = sent | job[i][9] | job[i][8];
      step();
    end
    set_req(r, 1'b0);
    set_data(r, 8'h00, 1'b0, 1'b0);
    junk(!r);
    sme_valid = 1'b0;
    step();
    chk("gnt_drop", {30'b0, gnt1, gnt0}, 32'd0);
    if (!sent) begin
      chk("abort_busy", 32'(busy), 32'd0);
      return;
    end
    model_last = r;
    k  = (k_in > 0) ? k_in : $urandom_range(1, KMAX);
    m  = (k_in > 0) ? m_in : 1'($urandom);
    ix = (k_in > 0) ? i_in : 5'($urandom);
    cycles = tmo ? TO : k;
    if (tmo) exp_q.push_back('{id: r, match: 1'b0, idx: 5'd0, tmo: 1'b1});
    else     exp_q.push_back('{id: r, match: m, idx: ix, tmo: 1'b0});
    for (int w = 1; w <= cycles; w++) begin
      junk(1'b0);
      junk(1'b1);
      sme_valid       = (!tmo && w == k);
      sme_match       = sme_valid ? m  : 1'($urandom);
      sme_match_index = sme_valid ? ix : 5'($urandom);
      #1;
      chk("wait_chardata", 32'(sme_chardata), 32'd0);
      chk("wait_qualifiers", {30'b0, sme_isstring, sme_ispattern}, 32'd0);
      chk("wait_gnt", {30'b0, gnt1, gnt0}, 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_res_valid", 32'(res_valid), 32'd0);
      step();
    end
    chk("report_res_valid", 32'(res_valid), 32'd1);
    sme_valid = 1'($urandom);
    junk(1'b0);
    junk(1'b1);
    #1;
    chk("report_chardata", 32'(sme_chardata), 32'd0);
    step();
    sme_valid = 1'b0;
    set_data(r, 8'h00, 1'b0, 1'b0);
    chk("idle_res_valid", 32'(res_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic single(input bit r, input bit do_sp, input bit tmo);
    job_t j;
    j = mk_job(do_sp);
    set_req(r, 1'b1);
    junk(!r);
    expect_grant(r);
    serve(r, tmo, j, 0, 1'b0, 5'd0);
  endtask

  task automatic tie(input bit sp_w, input bit sp_l, input bit tmo);
    bit   w;
    job_t jw, jl;
    w  = !model_last;
    jw = mk_job(sp_w);
    jl = mk_job(sp_l);
    req0 = 1'b1;
    req1 = 1'b1;
    expect_grant(w);
    serve(w, tmo, jw, 0, 1'b0, 5'd0);
    expect_grant(!w);
    serve(!w, 1'b0, jl, 0, 1'b0, 5'd0);
  endtask

  // Called shortly after a negedge; leaves reset released mid low phase.
  task automatic do_reset();
    #1 reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; sme_valid = 1'b0;
    set_data(1'b0, 8'h00, 1'b0, 1'b0);
    set_data(1'b1, 8'h00, 1'b0, 1'b0);
    #1;
    chk("rst_gnt", {30'b0, gnt1, gnt0}, 32'd0);
    chk("rst_sme_out", {22'b0, sme_chardata, sme_isstring, sme_ispattern}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res", {24'b0, res_valid, res_id, res_match, res_timeout, res_index}, 32'd0);
    model_last = 1'b1;
    step();
    step();
    #2 reset = 1'b0;
  endtask

  // Result monitor: pops the scoreboard on res_valid, otherwise checks the hold.
  initial begin
    res_t held, e;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = '0;
      end else if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("res_valid_unexpected", 32'(res_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_id", 32'(res_id), 32'(e.id));
          chk("res_match", 32'(res_match), 32'(e.match));
          chk("res_index", 32'(res_index), 32'(e.idx));
          chk("res_timeout", 32'(res_timeout), 32'(e.tmo));
          held = e;
        end
      end else begin
        chk("hold_res", {28'b0, res_id, res_match, res_timeout, 1'b0},
            {28'b0, held.id, held.match, held.tmo, 1'b0});
        chk("hold_res_index", 32'(res_index), 32'(held.idx));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t  j31;
    string sa;
    bit    tmo;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = '0;
    set_data(1'b0, 8'h00, 1'b0, 1'b0);
    set_data(1'b1, 8'h00, 1'b0, 1'b0);
    step();
    chk("reset_gnt", {30'b0, gnt1, gnt0}, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_res", {24'b0, res_valid, res_id, res_match, res_timeout, res_index}, 32'd0);
    #2 reset = 1'b0;
    step();

    // Ties after reset: req0, then req1, then req0 again.
    tie(1'b1, 1'b1, 1'b0);
    tie(1'b1, 1'b1, 1'b0);

    // req0 alone: string "ab cd" then pattern "cd", match at index 3.
    sa = "ab cd";
    for (int i = 0; i < sa.len(); i++) j31.push_back({1'b1, 1'b0, sa[i]});
    sa = "cd";
    for (int i = 0; i < sa.len(); i++) j31.push_back({1'b0, 1'b1, sa[i]});
    req0 = 1'b1;
    expect_grant(1'b0);
    serve(1'b0, 1'b0, j31, 1, 1'b1, 5'd3);

    // req1 job with no string/pattern: aborts silently.
    single(1'b1, 1'b0, 1'b0);

`ifdef SME_ARB_TIMEOUT_EN
    single(1'b0, 1'b1, 1'b1);
    single(1'b1, 1'b1, 1'b1);
`endif

    // Reset mid-STREAM with isstring high.
    req0 = 1'b1;
    expect_grant(1'b0);
    set_data(1'b0, 8'h5a, 1'b1, 1'b0);
    #1 chk("pre_reset_isstring", 32'(sme_isstring), 32'd1);
    do_reset();
    step();
    single(1'b0, 1'b1, 1'b0);

    // Reset mid-WAIT.
    req1 = 1'b1;
    expect_grant(1'b1);
    set_data(1'b1, 8'h33, 1'b1, 1'b0);
    step();
    req1 = 1'b0;
    set_data(1'b1, 8'h00, 1'b0, 1'b0);
    step();
    chk("wait_before_reset_busy", 32'(busy), 32'd1);
    do_reset();
    step();
    tie(1'b1, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++) begin
`ifdef SME_ARB_TIMEOUT_EN
      tmo = ($urandom_range(0, 3) == 0);
`else
      tmo = 1'b0;
`endif
      if ($urandom_range(0, 2) == 0)
        tie($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, tmo);
      else
        single(1'($urandom), $urandom_range(0, 4) != 0, tmo);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (4) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sme_arb.md
SME_ARB -- requirements
Module: sme_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: WAIT-state cycle limit, valid range 1..255, held in an 8-bit counter.
REQ-002 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have req0/req1  input  1 each  requester job request, held high for the whole job stream.
REQ-005 SHALL have gnt0/gnt1  output  1 each  registered grant, at most one high.
REQ-006 SHALL have d0/d1  input  8 each  requester character data.
REQ-007 SHALL have s0/s1 and p0/p1  input  1 each  requester isstring/ispattern qualifiers.
REQ-008 SHALL have sme_chardata  output  8, plus sme_isstring and sme_ispattern  output  1 each: the muxed stream to the matcher.
REQ-009 SHALL have sme_valid, sme_match  input  1 each, and sme_match_index  input  5: matcher result.
REQ-010 SHALL have res_valid, res_id, res_match, res_timeout  output  1 each, and res_index  output  5: tagged result.
REQ-011 SHALL have busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, STREAM, WAIT, REPORT.
REQ-013 In IDLE with any req high, the block SHALL enter STREAM and assert the chosen gnt on the next edge.
REQ-014 Round-robin: single requester SHALL be granted; with both high, the requester not served last SHALL win; after reset, req0 wins a tie.
REQ-015 In STREAM, sme_chardata/sme_isstring/sme_ispattern SHALL combinationally equal the granted requester's d/s/p; in all other states they SHALL be 0.
REQ-016 STREAM SHALL set a sent flag when a granted s or p is seen high.
REQ-017 When the granted req falls: with sent set, the block SHALL go to WAIT; with sent clear, it SHALL go to IDLE with no result (abort).
REQ-018 gnt SHALL drop on the same edge that leaves STREAM; the last-served pointer SHALL update only on STREAM->WAIT.
REQ-019 The ungranted requester's s/p/d SHALL be ignored at all times, and its req SHALL stay pending.
REQ-020 In WAIT, sme_valid high SHALL latch sme_match and sme_match_index and move to REPORT.
REQ-021 REPORT SHALL last exactly one cycle, with res_valid=1, res_id=served requester, and latched match/index; the block SHALL then return to IDLE.
REQ-022 Outside REPORT, res_valid SHALL be 0; res_id, res_match, res_index and res_timeout SHALL hold their last values.
REQ-023 Minimum turnaround from the REPORT edge to the next grant SHALL be 2 cycles (REPORT->IDLE->STREAM).
REQ-024 sme_valid outside WAIT SHALL be ignored.

Reset
REQ-025 Reset SHALL force state IDLE, gnt0=gnt1=0, res_valid=res_id=res_match=res_timeout=0, res_index=0, busy=0, sent=0, pointer=req1-last, and timeout counter=0.
REQ-026 Reset mid-STREAM or mid-WAIT SHALL discard the job without a result; the first request after release SHALL follow REQ-013.

Configuration
REQ-027 Macro SME_ARB_TIMEOUT_EN SHALL control the WAIT timeout.
REQ-028 With SME_ARB_TIMEOUT_EN defined, the counter SHALL clear on WAIT entry and increment each WAIT cycle; at TIMEOUT_CYC with no sme_valid, the block SHALL enter REPORT with res_match=0, res_index=0, res_timeout=1.
REQ-029 With SME_ARB_TIMEOUT_EN defined, sme_valid SHALL win over a same-cycle timeout, and res_timeout SHALL be 0 for normal results.
REQ-030 Without SME_ARB_TIMEOUT_EN, the counter logic SHALL be absent, res_timeout SHALL be tied to 0, and WAIT SHALL be left only on sme_valid.

Verification
REQ-031 req0 alone, string "ab cd" then pattern "cd", req0 drops, sme_valid with match=1 index=3 -> gnt0 one cycle after req0; res_valid pulse with id=0, match=1, index=3.
REQ-032 req0 and req1 high together after reset -> gnt0 first; after report, gnt1 with req1 held; a third tie -> gnt0.
REQ-033 req1 rises and falls with no s/p -> no sme activity, no res_valid; block returns to IDLE and busy drops.
REQ-034 With macro, TIMEOUT_CYC=4 and sme_valid never asserted -> res_valid with res_timeout=1 and match=0 on the cycle after the 4th WAIT cycle.
REQ-035 Reset asserted mid-STREAM while sme_isstring=1 -> gnt and sme_* outputs 0 immediately; no res_valid follows.
REQ-036 While req0 is granted, req1 toggles s1/p1 with d1=8'h41 -> sme_chardata never shows 8'h41 during req0's stream.
